// File: rtl/scalar_wb_arbiter_if.sv
// Writeback bus between the scalar execution units and the register-file write port.
// master: execution units / register file side; slave: the writeback arbiter.
interface scalar_wb_arbiter_if;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mul_valid;
  logic        mul_ready;
  logic [4:0]  mul_rd;
  logic [31:0] mul_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [1:0]  wb_src;
  logic        alu_stall;
  logic        err_alu_overrun;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output mul_valid, mul_rd, mul_data,
    output lsu_valid, lsu_rd, lsu_data,
    input  mul_ready, lsu_ready,
    input  rf_we, rf_waddr, rf_wdata, wb_src, alu_stall, err_alu_overrun
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mul_valid, mul_rd, mul_data,
    input  lsu_valid, lsu_rd, lsu_data,
    output mul_ready, lsu_ready,
    output rf_we, rf_waddr, rf_wdata, wb_src, alu_stall, err_alu_overrun
  );
endinterface

// File: rtl/scalar_wb_arbiter.sv
// Scalar writeback arbiter: merges ALU, MUL/DIV and LSU results into one registered
// register-file write port. ALU has fixed priority, MUL/LSU share round-robin, and a
// starvation counter raises alu_stall so a pending MUL/LSU result eventually wins.
module scalar_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  scalar_wb_arbiter_if.slave   wb
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_ALU  = 2'd1;
  localparam logic [1:0] SRC_MUL  = 2'd2;
  localparam logic [1:0] SRC_LSU  = 2'd3;

  logic             rr_ptr;
  logic [CNT_W-1:0] starve_cnt;
  logic             grant_alu;
  logic             grant_mul;
  logic             grant_lsu;

  // Grant selection: ALU first, then MUL/LSU by availability and round-robin pointer
  always_comb begin
    grant_alu = wb.alu_valid;
    grant_mul = 1'b0;
    grant_lsu = 1'b0;
    if (!wb.alu_valid) begin
      if (wb.mul_valid && wb.lsu_valid) begin
        grant_mul = !rr_ptr;
        grant_lsu = rr_ptr;
      end else begin
        grant_mul = wb.mul_valid;
        grant_lsu = wb.lsu_valid;
      end
    end
  end

  assign wb.mul_ready = grant_mul;
  assign wb.lsu_ready = grant_lsu;
  assign wb.alu_stall = (starve_cnt == CNT_W'(STARVE_LIMIT));

  // Writeback register: one-cycle write strobe per accepted result, rd==0 suppresses the write
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb.rf_we    <= 1'b0;
      wb.rf_waddr <= '0;
      wb.rf_wdata <= '0;
      wb.wb_src   <= SRC_NONE;
    end else if (grant_alu) begin
      wb.rf_we    <= (wb.alu_rd != 5'd0);
      wb.rf_waddr <= wb.alu_rd;
      wb.rf_wdata <= wb.alu_data;
      wb.wb_src   <= SRC_ALU;
    end else if (grant_mul) begin
      wb.rf_we    <= (wb.mul_rd != 5'd0);
      wb.rf_waddr <= wb.mul_rd;
      wb.rf_wdata <= wb.mul_data;
      wb.wb_src   <= SRC_MUL;
    end else if (grant_lsu) begin
      wb.rf_we    <= (wb.lsu_rd != 5'd0);
      wb.rf_waddr <= wb.lsu_rd;
      wb.rf_wdata <= wb.lsu_data;
      wb.wb_src   <= SRC_LSU;
    end else begin
      wb.rf_we    <= 1'b0;
      wb.wb_src   <= SRC_NONE;
    end
  end

  // Round-robin pointer: points away from whichever of MUL/LSU was last granted
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= 1'b0;
    end else if (grant_mul) begin
      rr_ptr <= 1'b1;
    end else if (grant_lsu) begin
      rr_ptr <= 1'b0;
    end
  end

  // Starvation counter: counts ALU wins over pending MUL/LSU work, saturating at the limit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (grant_mul || grant_lsu || !(wb.mul_valid || wb.lsu_valid)) begin
      starve_cnt <= '0;
    end else if (wb.alu_valid && (starve_cnt != CNT_W'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  // Sticky overrun flag: issue stage ignored alu_stall
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb.err_alu_overrun <= 1'b0;
    end else if (wb.alu_valid && wb.alu_stall) begin
      wb.err_alu_overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_scalar_wb_arbiter.sv
// Directed testbench for scalar_wb_arbiter with hand-computed expectations.
module tb_scalar_wb_arbiter;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  scalar_wb_arbiter_if bus ();

  scalar_wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.mul_valid = 1'b0; bus.mul_rd = '0; bus.mul_data = '0;
    bus.lsu_valid = 1'b0; bus.lsu_rd = '0; bus.lsu_data = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    do_reset();

    // reset state
    check_val("rst_we",    32'(bus.rf_we), 32'd0);
    check_val("rst_waddr", 32'(bus.rf_waddr), 32'd0);
    check_val("rst_wdata", bus.rf_wdata, 32'd0);
    check_val("rst_src",   32'(bus.wb_src), 32'd0);
    check_val("rst_stall", 32'(bus.alu_stall), 32'd0);
    check_val("rst_err",   32'(bus.err_alu_overrun), 32'd0);
    check_val("rst_mrdy",  32'(bus.mul_ready), 32'd0);
    check_val("rst_lrdy",  32'(bus.lsu_ready), 32'd0);

    // 1: ALU only
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
    tick();
    bus.alu_valid = 1'b0;
    check_val("t1_we",    32'(bus.rf_we), 32'd1);
    check_val("t1_waddr", 32'(bus.rf_waddr), 32'd5);
    check_val("t1_wdata", bus.rf_wdata, 32'hDEADBEEF);
    check_val("t1_src",   32'(bus.wb_src), 32'd1);
    tick();
    check_val("t1_idle_we",    32'(bus.rf_we), 32'd0);
    check_val("t1_idle_src",   32'(bus.wb_src), 32'd0);
    check_val("t1_idle_waddr", 32'(bus.rf_waddr), 32'd5);
    check_val("t1_idle_wdata", bus.rf_wdata, 32'hDEADBEEF);

    // 2: ALU and MUL together, MUL waits one cycle
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'h0000_0033;
    bus.mul_valid = 1'b1; bus.mul_rd = 5'd4; bus.mul_data = 32'h0000_0044;
    #1;
    check_val("t2_mrdy0", 32'(bus.mul_ready), 32'd0);
    tick();
    bus.alu_valid = 1'b0;
    check_val("t2_alu_addr", 32'(bus.rf_waddr), 32'd3);
    check_val("t2_alu_src",  32'(bus.wb_src), 32'd1);
    #1;
    check_val("t2_mrdy1", 32'(bus.mul_ready), 32'd1);
    tick();
    bus.mul_valid = 1'b0;
    check_val("t2_mul_we",   32'(bus.rf_we), 32'd1);
    check_val("t2_mul_addr", 32'(bus.rf_waddr), 32'd4);
    check_val("t2_mul_data", bus.rf_wdata, 32'h0000_0044);
    check_val("t2_mul_src",  32'(bus.wb_src), 32'd2);

    // 3: MUL and LSU both valid from reset alternate MUL, LSU, MUL, LSU
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.mul_valid = 1'b1; bus.mul_rd = 5'(8 + i);  bus.mul_data = 32'h1000 + 32'(i);
      bus.lsu_valid = 1'b1; bus.lsu_rd = 5'(16 + i); bus.lsu_data = 32'h2000 + 32'(i);
      #1;
      check_val($sformatf("t3_mrdy%0d", i), 32'(bus.mul_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      check_val($sformatf("t3_lrdy%0d", i), 32'(bus.lsu_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
      tick();
      check_val($sformatf("t3_src%0d", i), 32'(bus.wb_src), (i % 2 == 0) ? 32'd2 : 32'd3);
      check_val($sformatf("t3_data%0d", i), bus.rf_wdata,
                (i % 2 == 0) ? 32'h1000 + 32'(i) : 32'h2000 + 32'(i));
    end
    idle_inputs();
    tick();

    // 4: ALU every cycle with LSU pending raises alu_stall after 4 ALU wins
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd7; bus.lsu_data = 32'h0000_0077;
    for (int i = 0; i < 4; i++) begin
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'(i);
      #1;
      check_val($sformatf("t4_stall_pre%0d", i), 32'(bus.alu_stall), 32'd0);
      check_val($sformatf("t4_lrdy%0d", i), 32'(bus.lsu_ready), 32'd0);
      tick();
      check_val($sformatf("t4_src%0d", i), 32'(bus.wb_src), 32'd1);
    end
    check_val("t4_stall_up", 32'(bus.alu_stall), 32'd1);
    bus.alu_valid = 1'b0;
    #1;
    check_val("t4_lrdy_go", 32'(bus.lsu_ready), 32'd1);
    tick();
    bus.lsu_valid = 1'b0;
    check_val("t4_lsu_src",   32'(bus.wb_src), 32'd3);
    check_val("t4_lsu_addr",  32'(bus.rf_waddr), 32'd7);
    check_val("t4_stall_dn",  32'(bus.alu_stall), 32'd0);
    check_val("t4_err",       32'(bus.err_alu_overrun), 32'd0);

    // 5: ALU kept high while stalled still wins and sets the sticky error
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd10; bus.lsu_data = 32'h0000_00AA;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd2;
    for (int i = 0; i < 4; i++) begin
      bus.alu_data = 32'h5000 + 32'(i);
      tick();
    end
    check_val("t5_stall", 32'(bus.alu_stall), 32'd1);
    check_val("t5_err_pre", 32'(bus.err_alu_overrun), 32'd0);
    bus.alu_data = 32'h0000_5555;
    tick();
    check_val("t5_alu_src",  32'(bus.wb_src), 32'd1);
    check_val("t5_alu_data", bus.rf_wdata, 32'h0000_5555);
    check_val("t5_err_set",  32'(bus.err_alu_overrun), 32'd1);
    bus.alu_valid = 1'b0;
    tick();
    bus.lsu_valid = 1'b0;
    check_val("t5_lsu_src",  32'(bus.wb_src), 32'd3);
    check_val("t5_err_hold", 32'(bus.err_alu_overrun), 32'd1);

    // 6: LSU to rd 0 is accepted but not written; reset mid-stream clears everything
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd0; bus.lsu_data = 32'h0000_1234;
    #1;
    check_val("t6_lrdy", 32'(bus.lsu_ready), 32'd1);
    tick();
    bus.lsu_valid = 1'b0;
    check_val("t6_we0",  32'(bus.rf_we), 32'd0);
    check_val("t6_src",  32'(bus.wb_src), 32'd3);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'h0000_0099;
    tick();
    check_val("t6_alu_we", 32'(bus.rf_we), 32'd1);
    rst_n = 1'b0;
    tick();
    check_val("t6_rst_we",    32'(bus.rf_we), 32'd0);
    check_val("t6_rst_waddr", 32'(bus.rf_waddr), 32'd0);
    check_val("t6_rst_wdata", bus.rf_wdata, 32'd0);
    check_val("t6_rst_src",   32'(bus.wb_src), 32'd0);
    check_val("t6_rst_stall", 32'(bus.alu_stall), 32'd0);
    check_val("t6_rst_err",   32'(bus.err_alu_overrun), 32'd0);
    rst_n = 1'b1;
    idle_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
